// File: rtl/z_monitor_pkg.sv
// Shared types and defaults for the bounded safety-property observer.
// Holds the observer state encoding and the 2-bit stimulus type.
package z_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam int MAX_DEPTH_DEF = 8;
    localparam int DEPTH_DEF     = 4;

    typedef logic [1:0] stim_t;

endpackage

// File: rtl/z_monitor_if.sv
// Observer bus: run control, observed circuit signals, verdict and trace read port.
// Master drives stimulus/requests; slave (the monitor) returns verdict and read data.
interface z_monitor_if #(
    parameter int CW = 3,
    parameter int IW = 2
);
    logic                  start;
    z_monitor_pkg::stim_t  add;
    logic                  z;
    logic                  busy;
    logic                  pass;
    logic                  fail;
    logic [CW-1:0]         fail_depth;
    logic                  rd_req;
    logic [IW-1:0]         rd_idx;
    logic                  rd_valid;
    z_monitor_pkg::stim_t  rd_data;

    modport master (
        output start, add, z, rd_req, rd_idx,
        input  busy, pass, fail, fail_depth, rd_valid, rd_data
    );

    modport slave (
        input  start, add, z, rd_req, rd_idx,
        output busy, pass, fail, fail_depth, rd_valid, rd_data
    );
endinterface

// File: rtl/z_monitor_trace.sv
// Stimulus trace shift buffer (entry 0 = newest) with registered read port, 1-cycle read latency.
// No backpressure: every request gets a response the next cycle; reads see pre-shift contents.
module z_monitor_trace
    import z_monitor_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift,
    input  logic          clear,
    input  stim_t         din,
    input  logic          rd_req,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output stim_t         rd_data
);

    stim_t trace_q [DEPTH];
    stim_t sel;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) trace_q[i] <= '0;
        end else if (shift) begin
            trace_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) trace_q[i] <= trace_q[i-1];
        end
    end

    // Indices at or beyond DEPTH match no entry and fall through to zero.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IW'(i)) sel = trace_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= rd_req ? sel : '0;
        end
    end

endmodule

// File: rtl/z_monitor.sv
// Bounded observer: flags z within MAX_DEPTH cycles per run; verdict 1 cycle after sampling.
// No backpressure; trace storage only when Z_MONITOR_TRACE_EN is defined.
module z_monitor
    import z_monitor_pkg::*;
#(
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
    parameter int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic         clk,
    input logic         reset,
    z_monitor_if.slave  bus
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] fd_q, fd_d;
    logic          shift;
    logic          clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fd_d    = fd_q;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_RUN: begin
                shift = 1'b1;
                // A violation on the last bound cycle still counts as a failure.
                if (bus.z) begin
                    state_d = ST_FAIL;
                    fd_d    = cnt_q;
                end else if (cnt_q == CW'(MAX_DEPTH - 1)) begin
                    state_d = ST_PASS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    fd_d    = '0;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.pass       = (state_q == ST_PASS);
    assign bus.fail       = (state_q == ST_FAIL);
    assign bus.fail_depth = fd_q;

`ifdef Z_MONITOR_TRACE_EN
    z_monitor_trace #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_trace (
        .clk      (clk),
        .reset    (reset),
        .shift    (shift),
        .clear    (clear),
        .din      (bus.add),
        .rd_req   (bus.rd_req),
        .rd_idx   (bus.rd_idx),
        .rd_valid (bus.rd_valid),
        .rd_data  (bus.rd_data)
    );
`else
    logic rd_valid_q;
    logic unused_ok;

    always_ff @(posedge clk) begin
        if (reset) rd_valid_q <= 1'b0;
        else       rd_valid_q <= bus.rd_req;
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = '0;
    assign unused_ok    = ^{bus.add, bus.rd_idx, shift, clear};
`endif

endmodule
